// File: rtl/mixer_pkg.sv
// Shared types and helpers for the TDM voice mixer.
// Accumulator sizing and signed saturation live here so sibling mixers agree.
package mixer_pkg;

    typedef enum logic [1:0] {IDLE, ACCUM, SCALE, OUT} mix_state_t;

    localparam int SAT_W = 64;

    function automatic int acc_width(input int num_voices, input int sample_w, input int gain_w);
        return sample_w + gain_w + 1 + $clog2(num_voices);
    endfunction

    function automatic int unity(input int w);
        return 1 << (w - 1);
    endfunction

    function automatic logic signed [SAT_W-1:0] sat_signed(input logic signed [SAT_W-1:0] value,
                                                           input int width);
        logic signed [SAT_W-1:0] one;
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        one = {{(SAT_W-1){1'b0}}, 1'b1};
        hi  = (one <<< (width - 1)) - one;
        lo  = -(one <<< (width - 1));
        if (value > hi) begin
            return hi;
        end else if (value < lo) begin
            return lo;
        end
        return value;
    endfunction

endpackage

// File: rtl/edge_sync_detect.sv
// Two-flop synchroniser for an asynchronous level, plus a one-cycle rising-edge pulse.
// Pulse appears two clocks after the input is first captured.
module edge_sync_detect (
    input  logic clk,
    input  logic reset,
    input  logic async_in,
    output logic rise_pulse
);

    logic sync1_q;
    logic sync2_q;
    logic prev_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= async_in;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign rise_pulse = sync2_q & ~prev_q;

endmodule

// File: rtl/voice_mixer_tdm.sv
// Time-multiplexed mixer: one voice MAC per cycle, master volume, saturation.
// Result valid NUM_VOICES+2 cycles after the LRCLK tick; ticks arriving while busy are dropped and flagged.
module voice_mixer_tdm
    import mixer_pkg::*;
#(
    parameter int NUM_VOICES = 8,
    parameter int SAMPLE_W   = 24,
    parameter int GAIN_W     = 8,
    parameter int MVOL_W     = 8
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           sample_clock,
    input  logic [NUM_VOICES*SAMPLE_W-1:0] voice_sample,
    input  logic [NUM_VOICES*GAIN_W-1:0]   voice_gain,
    input  logic [NUM_VOICES-1:0]          voice_enable,
    input  logic [MVOL_W-1:0]              master_vol,
    input  logic                           clr_flags,
    output logic [SAMPLE_W-1:0]            mixed_sample,
    output logic                           mixed_valid,
    output logic                           busy,
    output logic                           clip,
    output logic                           overrun
);

    localparam int ACC_W = acc_width(NUM_VOICES, SAMPLE_W, GAIN_W);
    localparam int SCL_W = ACC_W + MVOL_W + 1;
    localparam int IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VOICES - 1);

    logic tick;

    mix_state_t              state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic [SAMPLE_W-1:0]     mixed_sample_q, mixed_sample_d;
    logic                    mixed_valid_q, mixed_valid_d;
    logic                    clip_q, clip_d;
    logic                    overrun_q, overrun_d;

    logic [SAMPLE_W-1:0]     samp_q [NUM_VOICES];
    logic [SAMPLE_W-1:0]     samp_d [NUM_VOICES];
    logic [GAIN_W-1:0]       gain_q [NUM_VOICES];
    logic [GAIN_W-1:0]       gain_d [NUM_VOICES];
    logic [NUM_VOICES-1:0]   en_q, en_d;
    logic [MVOL_W-1:0]       mvol_q, mvol_d;

    logic signed [ACC_W-1:0] samp_ext, gain_ext, term, acc_sh;
    logic signed [SCL_W-1:0] acc_ext, mvol_ext, scaled;
    logic signed [SAT_W-1:0] scaled_wide, sat_val;

    edge_sync_detect u_lrclk_sync (
        .clk        (clk),
        .reset      (reset),
        .async_in   (sample_clock),
        .rise_pulse (tick)
    );

    always_comb begin
        state_d        = state_q;
        idx_d          = idx_q;
        acc_d          = acc_q;
        mixed_sample_d = mixed_sample_q;
        mixed_valid_d  = 1'b0;
        clip_d         = clip_q;
        overrun_d      = overrun_q;
        samp_d         = samp_q;
        gain_d         = gain_q;
        en_d           = en_q;
        mvol_d         = mvol_q;

        // Gain is zero-extended so the product is signed x unsigned.
        samp_ext = {{(ACC_W-SAMPLE_W){samp_q[idx_q][SAMPLE_W-1]}}, samp_q[idx_q]};
        gain_ext = {{(ACC_W-GAIN_W){1'b0}}, gain_q[idx_q]};
        term     = en_q[idx_q] ? samp_ext * gain_ext : '0;

        acc_sh      = acc_q >>> (GAIN_W - 1);
        acc_ext     = {{(SCL_W-ACC_W){acc_sh[ACC_W-1]}}, acc_sh};
        mvol_ext    = {{(SCL_W-MVOL_W){1'b0}}, mvol_q};
        scaled      = (acc_ext * mvol_ext) >>> (MVOL_W - 1);
        scaled_wide = {{(SAT_W-SCL_W){scaled[SCL_W-1]}}, scaled};
        sat_val     = sat_signed(scaled_wide, SAMPLE_W);

        // Clear first so a same-cycle set keeps the flag high.
        if (clr_flags) begin
            clip_d    = 1'b0;
            overrun_d = 1'b0;
        end
        if (tick && state_q != IDLE) begin
            overrun_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (tick) begin
                    for (int i = 0; i < NUM_VOICES; i++) begin
                        samp_d[i] = voice_sample[i*SAMPLE_W +: SAMPLE_W];
                        gain_d[i] = voice_gain[i*GAIN_W +: GAIN_W];
                    end
                    en_d    = voice_enable;
                    mvol_d  = master_vol;
                    acc_d   = '0;
                    idx_d   = '0;
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                acc_d = acc_q + term;
                idx_d = idx_q + IDX_W'(1);
                if (idx_q == LAST_IDX) begin
                    state_d = SCALE;
                end
            end
            // Scale and clamp are registered here so the result and its valid
            // pulse are both visible during the OUT cycle.
            SCALE: begin
                mixed_sample_d = sat_val[SAMPLE_W-1:0];
                mixed_valid_d  = 1'b1;
                if (sat_val != scaled_wide) begin
                    clip_d = 1'b1;
                end
                state_d = OUT;
            end
            OUT: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            idx_q          <= '0;
            acc_q          <= '0;
            mixed_sample_q <= '0;
            mixed_valid_q  <= 1'b0;
            clip_q         <= 1'b0;
            overrun_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            acc_q          <= acc_d;
            mixed_sample_q <= mixed_sample_d;
            mixed_valid_q  <= mixed_valid_d;
            clip_q         <= clip_d;
            overrun_q      <= overrun_d;
        end
    end

    // Frame snapshot is only consumed after a tick reloads it, so it needs no reset.
    always_ff @(posedge clk) begin
        samp_q <= samp_d;
        gain_q <= gain_d;
        en_q   <= en_d;
        mvol_q <= mvol_d;
    end

    assign mixed_sample = mixed_sample_q;
    assign mixed_valid  = mixed_valid_q;
    assign busy         = (state_q != IDLE);
    assign clip         = clip_q;
    assign overrun      = overrun_q;

endmodule
